// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage controller between EX/MEM and MEM/WB.
// Issues loads/stores to a variable-latency data memory over req/ack, stalls
// the upstream pipeline while an access is outstanding and formats load data.
// Optional build macro: MEM_MISALIGN_TRAP_EN makes misaligned half/word
// accesses skip the memory and report mem_err_o instead.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] MemWData_i,
    input  logic [4:0]  Rd_i,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [31:0] ALUResult_o,
    output logic [4:0]  Rd_o,
    output logic [31:0] DATARd_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_req;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [3:0]       r_be;
    logic [31:0]      r_wdata;
    logic [31:0]      r_data;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;

    logic             w_mem_op;
    logic             w_issue;
    logic             w_capture;
    logic             w_abort;
    logic             w_trap;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [7:0]       w_lbyte;
    logic [15:0]      w_lhalf;
    logic [31:0]      w_ldata;

`ifdef MEM_MISALIGN_TRAP_EN
    logic             r_trap;
    logic             w_misalign;

    // Half on an odd address or word off a word boundary cannot be issued
    assign w_misalign = ((funct3_i[1:0] == 2'b01) && ALUResult_i[0]) ||
                        (funct3_i[1] && (ALUResult_i[1:0] != 2'b00));
`endif

    assign w_mem_op  = MemRead_i | MemWrite_i;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // Pass-through fields never depend on state
    assign MemtoReg_o  = MemtoReg_i;
    assign ALUResult_o = ALUResult_i;
    assign Rd_o        = Rd_i;

    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_be_o    = r_be;
    assign mem_wdata_o = r_wdata;
    assign mem_err_o   = r_err;

    // Store lane selection: byte enables and lane-replicated write data
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = MemWData_i;
        case (funct3_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << ALUResult_i[1:0];
                w_wdata = {4{MemWData_i[7:0]}};
            end
            2'b01: begin
                w_be    = ALUResult_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{MemWData_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load formatting: pick the addressed lane and sign/zero extend
    always_comb begin
        w_lbyte = mem_rdata_i[7:0];
        case (ALUResult_i[1:0])
            2'b01:   w_lbyte = mem_rdata_i[15:8];
            2'b10:   w_lbyte = mem_rdata_i[23:16];
            2'b11:   w_lbyte = mem_rdata_i[31:24];
            default: w_lbyte = mem_rdata_i[7:0];
        endcase
        w_lhalf = ALUResult_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (funct3_i[1:0])
            2'b00:   w_ldata = funct3_i[2] ? {24'd0, w_lbyte} : {{24{w_lbyte[7]}}, w_lbyte};
            2'b01:   w_ldata = funct3_i[2] ? {16'd0, w_lhalf} : {{16{w_lhalf[15]}}, w_lhalf};
            default: w_ldata = mem_rdata_i;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, stall/bubble generation and datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        w_abort     = 1'b0;
        w_trap      = 1'b0;
        stall_o     = 1'b0;
        RegWrite_o  = RegWrite_i;
        DATARd_o    = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op) begin
                    stall_o     = 1'b1;
                    RegWrite_o  = 1'b0;
                    w_issue     = 1'b1;
                    w_state_nxt = S_WAIT;
`ifdef MEM_MISALIGN_TRAP_EN
                    if (w_misalign) begin
                        w_issue     = 1'b0;
                        w_trap      = 1'b1;
                        w_state_nxt = S_DONE;
                    end
`endif
                end
            end
            S_WAIT: begin
                stall_o    = 1'b1;
                RegWrite_o = 1'b0;
                if (mem_ack_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_cnt_inc == TIMEOUT_CNT) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                DATARd_o    = r_data;
`ifdef MEM_MISALIGN_TRAP_EN
                RegWrite_o  = RegWrite_i & ~r_trap;
`endif
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Reset releases the pipeline immediately, even mid-access
        if (!rst_n_i) begin
            stall_o = 1'b0;
        end
    end

    // Memory request and its held fields
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_be    <= 4'd0;
            r_wdata <= 32'd0;
        end else if (w_issue) begin
            r_req   <= 1'b1;
            r_we    <= MemWrite_i;
            r_addr  <= {ALUResult_i[31:2], 2'b00};
            r_be    <= MemWrite_i ? w_be : 4'b0000;
            r_wdata <= w_wdata;
        end else if (w_capture || w_abort) begin
            r_req   <= 1'b0;
        end
    end

    // Captured load data and error pulse
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_data <= 32'd0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_abort | w_trap;
            if (w_capture) begin
                r_data <= w_ldata;
            end else if (w_abort || w_trap) begin
                r_data <= 32'd0;
            end
        end
    end

    // WAIT-cycle counter for the timeout, cleared outside WAIT
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_cnt <= w_cnt_inc;
        end else begin
            r_cnt <= '0;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // Remembers that the DONE cycle belongs to a trapped access
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_trap <= 1'b0;
        end else begin
            r_trap <= w_trap;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized self-checking bench for mem_access_stage.
module tb_mem_access_stage;

    localparam int TO = 4;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i;
    logic [2:0]  funct3_i;
    logic [31:0] ALUResult_i, MemWData_i;
    logic [4:0]  Rd_i;
    logic        RegWrite_o, MemtoReg_o;
    logic [31:0] ALUResult_o;
    logic [4:0]  Rd_o;
    logic [31:0] DATARd_o;
    logic        stall_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_o;

    int n_vec = 0;
    int n_err = 0;

    mem_access_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
        .funct3_i(funct3_i), .ALUResult_i(ALUResult_i),
        .MemWData_i(MemWData_i), .Rd_i(Rd_i),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
        .ALUResult_o(ALUResult_o), .Rd_o(Rd_o), .DATARd_o(DATARd_o),
        .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .mem_err_o(mem_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: load result from raw word using shift/mask arithmetic
    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] v;
        logic [31:0] sh;
        if (f3[1:0] == 2'd0) begin
            sh = (a % 32'd4) * 32'd8;
            v  = (d >> sh) & 32'hFF;
            if (!f3[2] && v > 32'd127) v = v | 32'hFFFF_FF00;
        end else if (f3[1:0] == 2'd1) begin
            sh = ((a / 32'd2) % 32'd2) * 32'd16;
            v  = (d >> sh) & 32'hFFFF;
            if (!f3[2] && v > 32'd32767) v = v | 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    // Reference: store byte enables
    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] m;
        if (f3[1:0] == 2'd0)      m = 32'd1 << (a % 32'd4);
        else if (f3[1:0] == 2'd1) m = 32'd3 << (((a / 32'd2) % 32'd2) * 32'd2);
        else                      m = 32'hF;
        return m[3:0];
    endfunction

    // Reference: store data replicated across lanes
    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'd0)      return (d & 32'hFF) * 32'h0101_0101;
        else if (f3[1:0] == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        else                      return d;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle_inputs();
        MemRead_i = 1'b0; MemWrite_i = 1'b0; RegWrite_i = 1'b0; MemtoReg_i = 1'b0;
        funct3_i = 3'd0; ALUResult_i = 32'd0; MemWData_i = 32'd0; Rd_i = 5'd0;
        mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
    endtask

    // Drives one memory instruction through IDLE/WAIT/DONE, checking each cycle
    task automatic run_access(input logic rd, input logic wr, input logic rw, input logic m2r,
                              input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [4:0] rdst, input int delay, input logic [31:0] rdat,
                              input string tag);
        logic        trap, to, exp_rw;
        logic [31:0] exp_d;
        trap = TRAP_EN && (((f3[1:0] == 2'd1) && addr[0]) || (f3[1] && (addr[1:0] != 2'd0)));
        to   = (delay >= TO);
        MemRead_i = rd; MemWrite_i = wr; RegWrite_i = rw; MemtoReg_i = m2r;
        funct3_i = f3; ALUResult_i = addr; MemWData_i = wd; Rd_i = rdst; mem_ack_i = 1'b0;
        #1;
        n_vec++;
        if ({stall_o, RegWrite_o, mem_req_o} !== 3'b100) begin
            n_err++;
            $display("FAIL %s issue_ctl got %b exp 100", tag, {stall_o, RegWrite_o, mem_req_o});
        end
        step();
        if (!trap) begin
            for (int k = 0; k < TO; k++) begin
                n_vec++;
                if ({mem_req_o, stall_o, RegWrite_o, mem_we_o} !== {3'b110, wr}) begin
                    n_err++;
                    $display("FAIL %s wait_ctl cyc %0d got %b exp %b", tag, k,
                             {mem_req_o, stall_o, RegWrite_o, mem_we_o}, {3'b110, wr});
                end
                n_vec++;
                if (mem_addr_o !== {addr[31:2], 2'b00}) begin
                    n_err++;
                    $display("FAIL %s addr got %h exp %h", tag, mem_addr_o, {addr[31:2], 2'b00});
                end
                if (wr) begin
                    n_vec++;
                    if ({mem_be_o, mem_wdata_o} !== {m_be(f3, addr), m_wdata(f3, wd)}) begin
                        n_err++;
                        $display("FAIL %s store_lane got be=%b wd=%h exp be=%b wd=%h", tag,
                                 mem_be_o, mem_wdata_o, m_be(f3, addr), m_wdata(f3, wd));
                    end
                end
                mem_ack_i   = (k == delay);
                mem_rdata_i = mem_ack_i ? rdat : $urandom;
                step();
                if (k == delay) break;
            end
            mem_ack_i = 1'b0;
        end
        exp_d  = (trap || to) ? 32'd0 : m_load(f3, addr, rdat);
        exp_rw = trap ? 1'b0 : rw;
        n_vec++;
        if ({stall_o, mem_req_o, RegWrite_o, mem_err_o} !== {2'b00, exp_rw, (trap || to)}) begin
            n_err++;
            $display("FAIL %s done_ctl got %b exp %b", tag,
                     {stall_o, mem_req_o, RegWrite_o, mem_err_o}, {2'b00, exp_rw, (trap || to)});
        end
        if (!wr) begin
            n_vec++;
            if (DATARd_o !== exp_d) begin
                n_err++;
                $display("FAIL %s load_data got %h exp %h", tag, DATARd_o, exp_d);
            end
        end
        n_vec++;
        if ({Rd_o, ALUResult_o, MemtoReg_o} !== {rdst, addr, m2r}) begin
            n_err++;
            $display("FAIL %s done_passthru got %h/%h/%b exp %h/%h/%b", tag,
                     Rd_o, ALUResult_o, MemtoReg_o, rdst, addr, m2r);
        end
        idle_inputs();
        step();
        n_vec++;
        if ({mem_err_o, stall_o, mem_req_o} !== 3'b000) begin
            n_err++;
            $display("FAIL %s after_done got %b exp 000", tag, {mem_err_o, stall_o, mem_req_o});
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        idle_inputs();
        step();
        step();
        n_vec++;
        if ({mem_req_o, mem_err_o, stall_o, mem_we_o, mem_be_o, DATARd_o} !== 40'd0) begin
            n_err++;
            $display("FAIL reset got req=%b err=%b stall=%b we=%b be=%b d=%h exp all zero",
                     mem_req_o, mem_err_o, stall_o, mem_we_o, mem_be_o, DATARd_o);
        end
        rst_n_i = 1'b1;
        step();
    endtask

    task automatic test_passthrough();
        logic        rw, m2r;
        logic [31:0] alu;
        logic [4:0]  rd;
        for (int i = 0; i < 8; i++) begin
            rw  = (i == 0) ? 1'b1 : 1'($urandom);
            m2r = 1'($urandom);
            alu = $urandom;
            rd  = (i == 0) ? 5'd5 : 5'($urandom);
            MemRead_i = 1'b0; MemWrite_i = 1'b0; RegWrite_i = rw; MemtoReg_i = m2r;
            ALUResult_i = alu; Rd_i = rd; funct3_i = 3'($urandom);
            mem_ack_i = 1'($urandom);
            mem_rdata_i = $urandom;
            #1;
            n_vec++;
            if ({RegWrite_o, MemtoReg_o, ALUResult_o, Rd_o, stall_o, DATARd_o, mem_req_o}
                !== {rw, m2r, alu, rd, 1'b0, 32'd0, 1'b0}) begin
                n_err++;
                $display("FAIL passthru %0d got rw=%b rd=%0d alu=%h stall=%b d=%h req=%b exp rw=%b rd=%0d alu=%h",
                         i, RegWrite_o, Rd_o, ALUResult_o, stall_o, DATARd_o, mem_req_o, rw, rd, alu);
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_directed();
        run_access(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h100, 32'd0, 5'd3, 0, 32'hDEAD_BEEF, "lw_100");
        run_access(1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 32'h103, 32'd0, 5'd4, 1, 32'h80FF_FFFF, "lb_103");
        run_access(1'b1, 1'b0, 1'b1, 1'b1, 3'b100, 32'h103, 32'd0, 5'd4, 2, 32'h80FF_FFFF, "lbu_103");
        run_access(1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 32'h102, 32'h1234_ABCD, 5'd0, 0, 32'd0, "sh_102");
        run_access(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h201, 32'h0000_0077, 5'd0, 3, 32'd0, "rw_both");
        run_access(1'b1, 1'b0, 1'b1, 1'b1, 3'b101, 32'h102, 32'd0, 5'd9, 3, 32'h8001_7FFF, "lhu_ack_last");
        run_access(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h101, 32'd0, 5'd6, 0, 32'hCAFE_F00D, "lw_101");
    endtask

    task automatic test_timeout();
        run_access(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h300, 32'd0, 5'd7, TO + 5, 32'h1111_2222, "lw_timeout");
        run_access(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 32'h304, 32'h5555_AAAA, 5'd0, TO, 32'd0, "sw_timeout");
    endtask

    task automatic test_back_to_back();
        int          kind;
        logic [2:0]  f3;
        logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 3));
            if (kind == 0) begin
                f3 = ld_f3[$urandom_range(0, 4)];
                run_access(1'b1, 1'b0, 1'($urandom), 1'b1, f3, $urandom, $urandom,
                           5'($urandom), int'($urandom_range(0, 5)), $urandom, "rnd_load");
            end else begin
                f3 = 3'($urandom_range(0, 2));
                run_access(kind == 3, 1'b1, 1'b0, 1'b0, f3, $urandom, $urandom,
                           5'($urandom), int'($urandom_range(0, 5)), $urandom, "rnd_store");
            end
        end
    endtask

    task automatic test_reset_mid();
        MemRead_i = 1'b1; MemWrite_i = 1'b0; RegWrite_i = 1'b1; funct3_i = 3'b010;
        ALUResult_i = 32'h400; Rd_i = 5'd2; mem_ack_i = 1'b0;
        step();
        n_vec++;
        if ({mem_req_o, stall_o} !== 2'b11) begin
            n_err++;
            $display("FAIL rst_mid_pre got %b exp 11", {mem_req_o, stall_o});
        end
        rst_n_i = 1'b0;
        #1;
        n_vec++;
        if ({mem_req_o, stall_o} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_mid got %b exp 00", {mem_req_o, stall_o});
        end
        idle_inputs();
        step();
        rst_n_i = 1'b1;
        step();
        run_access(1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 32'h402, 32'd0, 5'd2, 1, 32'hF00D_1234, "lh_after_rst");
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_directed();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
